condicionador_entrada: RTL and testbench
========================================

CONDICIONADOR_ENTRADA -- requirements
Module: condicionador_entrada

Interface
REQ-001 The block SHALL have a parameter DEBOUNCE_CICLOS, default 4, giving the number of consecutive stable clock cycles required to accept a press or release (minimum 2).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have a port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have a port botao, input, 1 bit: raw asynchronous push-button, active-low (0 = pressed), may bounce.
REQ-005 The block SHALL have a port chaves, input, 4 bits: raw asynchronous digit switches.
REQ-006 The block SHALL have a port insere, output, 1 bit: active-low strobe; 0 for exactly one cycle per accepted press, otherwise 1; feeds the lock controller.
REQ-007 The block SHALL have a port numero, output, 4 bits: digit captured at acceptance; held stable until the next acceptance.
REQ-008 The block SHALL have a port invalido, output, 1 bit: 1 when the held numero is greater than 9.
REQ-009 The block SHALL have a port ocupado, output, 1 bit: 1 whenever the FSM is not in OCIOSO.

Function
REQ-010 botao and chaves SHALL each pass through a two-flop synchronizer before any use; the synchronized values are botao_s and chaves_s.
REQ-011 The FSM SHALL have the states OCIOSO, FILTRA_PRESSAO, PRESSIONADO and FILTRA_SOLTURA.
REQ-012 In OCIOSO, botao_s=0 SHALL cause a move to FILTRA_PRESSAO with the counter loaded to 1.
REQ-013 In FILTRA_PRESSAO, botao_s=1 SHALL cause a return to OCIOSO with the counter cleared and no strobe.
REQ-014 In FILTRA_PRESSAO, botao_s=0 SHALL increment the counter; when the counter equals DEBOUNCE_CICLOS, the FSM SHALL move to PRESSIONADO.
REQ-015 On the FILTRA_PRESSAO-to-PRESSIONADO edge, insere SHALL be registered to 0 for one cycle, numero SHALL be loaded with chaves_s, and invalido SHALL be loaded with (chaves_s > 9).
REQ-016 Latency: with botao held low, insere SHALL be 0 exactly during cycle 2+DEBOUNCE_CICLOS, counting from the first edge that samples botao=0 as cycle 0.
REQ-017 In PRESSIONADO, botao_s=1 SHALL cause a move to FILTRA_SOLTURA with the counter loaded to 1; no further strobe SHALL occur while the button is held, for any hold length.
REQ-018 In FILTRA_SOLTURA, botao_s=0 SHALL cause a return to PRESSIONADO (release bounce), with no strobe.
REQ-019 In FILTRA_SOLTURA, botao_s=1 SHALL increment the counter; at DEBOUNCE_CICLOS the FSM SHALL move to OCIOSO.
REQ-020 The counter SHALL be $clog2(DEBOUNCE_CICLOS+1) bits wide, SHALL never wrap, and SHALL be cleared on entry to OCIOSO and PRESSIONADO.
REQ-021 Changes on chaves outside the acceptance edge SHALL NOT affect numero or invalido.
REQ-022 Invalid digits (10..15) SHALL still produce a strobe; rejecting them is the consumer's responsibility, and invalido flags them.
REQ-023 All outputs SHALL be driven directly from flops, with no combinational path from any input to any output.

Reset
REQ-024 When reset=1 at a clock edge, the following SHALL take effect at that edge regardless of the current state: state=OCIOSO, counter=0, insere=1, numero=0, invalido=0, ocupado=0, botao synchronizer flops=1, chaves synchronizer flops=0.
REQ-025 A reset asserted during FILTRA_PRESSAO or in the strobe cycle SHALL suppress or cut the strobe; after reset release, insere SHALL be 1 until a fresh full debounce completes.

Structure
REQ-026 The state encodings and the default DEBOUNCE_CICLOS SHALL live in the shared project package/include file, together with the lock controller's state constants.
REQ-027 The two-flop synchronizer SHALL be the sub-module sincronizador, parameterized by width and reset value, and instantiated once for botao (reset value 1) and once for chaves (reset value 0).

Verification (DEBOUNCE_CICLOS=4)
REQ-028 Scenario 1: chaves=5, botao low for 12 cycles then high -> insere=0 only in cycle 6, numero=5, invalido=0, ocupado returns to 0 within 2+4+2 cycles after release.
REQ-029 Scenario 2: botao toggles low/high every cycle for 10 cycles -> insere stays 1 throughout; numero is unchanged.
REQ-030 Scenario 3: press held 40 cycles, with a 2-cycle high glitch at cycle 20 -> exactly one insere pulse.
REQ-031 Scenario 4: chaves=12 on press -> one strobe, numero=12, invalido=1; a subsequent press with chaves=9 -> numero=9, invalido=0.
REQ-032 Scenario 5: reset asserted in cycle 5 of a press -> no strobe and all outputs at reset values; a new 6-cycle press after release -> one strobe.
REQ-033 Scenario 6: chaves changed from 3 to 7 while in PRESSIONADO -> numero stays 3.

Source files
------------

// File: rtl/condicionador_entrada_pkg.sv
// Shared project package for the input conditioner and the lock controller.
// Holds the conditioner FSM encoding, the default debounce length, the lock
// controller state constants and a small digit-validity helper.
package condicionador_entrada_pkg;

  localparam int DEBOUNCE_CICLOS_PADRAO = 4;

  typedef enum logic [1:0] {
    OCIOSO         = 2'd0,
    FILTRA_PRESSAO = 2'd1,
    PRESSIONADO    = 2'd2,
    FILTRA_SOLTURA = 2'd3
  } estado_t;

  // Lock controller states, kept here so both blocks share one source.
  typedef enum logic [1:0] {
    FECH_BLOQUEADA = 2'd0,
    FECH_DIGITANDO = 2'd1,
    FECH_ABERTA    = 2'd2,
    FECH_ALARME    = 2'd3
  } estado_fechadura_t;

  function automatic logic digito_invalido(input logic [3:0] d);
    return d > 4'd9;
  endfunction

endpackage

// File: rtl/condicionador_entrada_if.sv
// Bus between the raw keypad/button inputs and the lock controller.
//   botao    : raw push-button, active-low, may bounce
//   chaves   : raw 4-bit digit switches
//   insere   : active-low one-cycle strobe per accepted press
//   numero   : digit captured at acceptance
//   invalido : held digit is above 9
//   ocupado  : conditioner is not idle
interface condicionador_entrada_if;
  logic       botao;
  logic [3:0] chaves;
  logic       insere;
  logic [3:0] numero;
  logic       invalido;
  logic       ocupado;

  modport master (output botao, chaves, input insere, numero, invalido, ocupado);
  modport slave  (input botao, chaves, output insere, numero, invalido, ocupado);
endinterface

// File: rtl/condicionador_entrada_sincronizador.sv
// Two-flop synchronizer for asynchronous inputs.
//   clk, reset : clock and synchronous active-high reset
//   d          : asynchronous input
//   q          : synchronized output (two clk edges of latency)
// RST_VAL lets each input come out of reset at its inactive level.
module sincronizador #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condicionador_entrada.sv
// Input conditioner: synchronizes and debounces an active-low push-button
// and captures the digit switches on each accepted press.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of condicionador_entrada_if
// A press (or release) is accepted once the synchronized button has held
// the new level for DEBOUNCE_CICLOS+1 consecutive samples. All outputs are
// registered.
module condicionador_entrada
  import condicionador_entrada_pkg::*;
#(
  parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
  input logic                    clk,
  input logic                    reset,
  condicionador_entrada_if.slave bus
);

  localparam int            CW      = $clog2(DEBOUNCE_CICLOS + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CICLOS);
  localparam logic [CW-1:0] CNT_UM  = CW'(1);

  logic          botao_s;
  logic [3:0]    chaves_s;
  estado_t       estado, estado_prox;
  logic [CW-1:0] cnt, cnt_prox;
  logic          aceita;

  sincronizador #(.W(1), .RST_VAL(1'b1)) u_sinc_botao (
    .clk   (clk),
    .reset (reset),
    .d     (bus.botao),
    .q     (botao_s)
  );

  sincronizador #(.W(4), .RST_VAL(4'd0)) u_sinc_chaves (
    .clk   (clk),
    .reset (reset),
    .d     (bus.chaves),
    .q     (chaves_s)
  );

  // Counter never exceeds CNT_MAX: every path that reaches it either leaves
  // the filter state or clears it.
  always_comb begin
    estado_prox = estado;
    cnt_prox    = cnt;
    aceita      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (!botao_s) begin
          estado_prox = FILTRA_PRESSAO;
          cnt_prox    = CNT_UM;
        end
      end
      FILTRA_PRESSAO: begin
        if (botao_s) begin
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else if (cnt == CNT_MAX) begin
          estado_prox = PRESSIONADO;
          cnt_prox    = '0;
          aceita      = 1'b1;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      PRESSIONADO: begin
        if (botao_s) begin
          estado_prox = FILTRA_SOLTURA;
          cnt_prox    = CNT_UM;
        end
      end
      FILTRA_SOLTURA: begin
        if (!botao_s) begin
          estado_prox = PRESSIONADO;
          cnt_prox    = '0;
        end else if (cnt == CNT_MAX) begin
          estado_prox = OCIOSO;
          cnt_prox    = '0;
        end else begin
          cnt_prox = cnt + CNT_UM;
        end
      end
      default: begin
        estado_prox = OCIOSO;
        cnt_prox    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      bus.insere   <= 1'b1;
      bus.numero   <= 4'd0;
      bus.invalido <= 1'b0;
      bus.ocupado  <= 1'b0;
    end else begin
      estado      <= estado_prox;
      cnt         <= cnt_prox;
      bus.insere  <= ~aceita;
      // Registered from next state so ocupado tracks the state flop exactly.
      bus.ocupado <= (estado_prox != OCIOSO);
      if (aceita) begin
        bus.numero   <= chaves_s;
        bus.invalido <= digito_invalido(chaves_s);
      end
    end
  end

endmodule

// File: tb/tb_condicionador_entrada.sv
// Self-checking bench for condicionador_entrada (DEBOUNCE_CICLOS = 4).
// Reference model: a level change is accepted once the synchronized button
// has shown the new level for D+1 consecutive samples; any sample at the old
// level restarts the run.
module tb_condicionador_entrada;

  localparam int D = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  condicionador_entrada_if bus ();

  condicionador_entrada #(.DEBOUNCE_CICLOS(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int strobes = 0;

  // behavioural model state
  logic       m_sb0, m_sb1;
  logic [3:0] m_sc0, m_sc1;
  logic       m_pressed;
  int         m_run;
  logic       m_insere, m_invalido, m_ocupado;
  logic [3:0] m_numero;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input logic b, input logic [3:0] c, input logic r);
    logic       bs;
    logic [3:0] cs;
    if (r) begin
      m_sb0 = 1'b1; m_sb1 = 1'b1; m_sc0 = 4'd0; m_sc1 = 4'd0;
      m_pressed = 1'b0; m_run = 0;
      m_insere = 1'b1; m_numero = 4'd0; m_invalido = 1'b0; m_ocupado = 1'b0;
    end else begin
      bs = m_sb1; cs = m_sc1;
      m_sb1 = m_sb0; m_sb0 = b;
      m_sc1 = m_sc0; m_sc0 = c;
      m_insere = 1'b1;
      // pressed means button low: the "new" level is bs == m_pressed
      if (bs == m_pressed) begin
        m_run++;
        if (m_run == D + 1) begin
          m_pressed = ~m_pressed;
          m_run = 0;
          if (m_pressed) begin
            m_insere   = 1'b0;
            m_numero   = cs;
            m_invalido = (cs > 4'd9);
          end
        end
      end else begin
        m_run = 0;
      end
      m_ocupado = m_pressed || (m_run > 0);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output.
  task automatic step(input logic b, input logic [3:0] c, input logic r);
    bus.botao  = b;
    bus.chaves = c;
    reset      = r;
    @(posedge clk);
    model_edge(b, c, r);
    #1;
    if (bus.insere === 1'b0) strobes++;
    n_tests++;
    if ({bus.insere, bus.numero, bus.invalido, bus.ocupado} !==
        {m_insere, m_numero, m_invalido, m_ocupado}) begin
      n_fail++;
      $display("FAIL model t=%0t: got ins=%b num=%0d inv=%b ocp=%b expected ins=%b num=%0d inv=%b ocp=%b",
               $time, bus.insere, bus.numero, bus.invalido, bus.ocupado,
               m_insere, m_numero, m_invalido, m_ocupado);
    end
  endtask

  task automatic do_reset();
    step(1'b1, 4'd0, 1'b1);
    step(1'b1, 4'd0, 1'b1);
  endtask

  typedef struct {
    logic [3:0] chaves;
    int         low_cycles;
    int         exp_strobes;
    logic [3:0] exp_numero;
    logic       exp_invalido;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s0;
    int done;
    int hold;
    logic b;
    logic [3:0] c;

    bus.botao = 1'b1; bus.chaves = 4'd0; reset = 1'b1;
    do_reset();
    check("reset_insere",   int'(bus.insere),   1);
    check("reset_numero",   int'(bus.numero),   0);
    check("reset_invalido", int'(bus.invalido), 0);
    check("reset_ocupado",  int'(bus.ocupado),  0);

    // Table: press lengths around the acceptance threshold (D+1 cycles low).
    vecs[0] = '{4'd5,  12, 1, 4'd5,  1'b0};
    vecs[1] = '{4'd12,  8, 1, 4'd12, 1'b1};
    vecs[2] = '{4'd9,   5, 1, 4'd9,  1'b0};
    vecs[3] = '{4'd3,   4, 0, 4'd9,  1'b0};
    vecs[4] = '{4'd15,  6, 1, 4'd15, 1'b1};
    vecs[5] = '{4'd0,   1, 0, 4'd15, 1'b1};
    vecs[6] = '{4'd10, 20, 1, 4'd10, 1'b1};
    for (int i = 0; i < 7; i++) begin
      s0 = strobes;
      for (int k = 0; k < vecs[i].low_cycles; k++) step(1'b0, vecs[i].chaves, 1'b0);
      for (int k = 0; k < 12; k++) step(1'b1, vecs[i].chaves, 1'b0);
      check($sformatf("vec%0d_strobes", i), strobes - s0, vecs[i].exp_strobes);
      check($sformatf("vec%0d_numero", i), int'(bus.numero), int'(vecs[i].exp_numero));
      check($sformatf("vec%0d_invalido", i), int'(bus.invalido), int'(vecs[i].exp_invalido));
      check($sformatf("vec%0d_ocupado", i), int'(bus.ocupado), 0);
    end

    // Scenario 1: strobe exactly in cycle 2+D, release returns to idle in time.
    do_reset();
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 4'd5, 1'b0);
      check($sformatf("s1_insere_c%0d", k), int'(bus.insere), (k == 2 + D) ? 0 : 1);
    end
    check("s1_numero", int'(bus.numero), 5);
    done = 0;
    for (int k = 0; k < 2 + D + 2 && done == 0; k++) begin
      step(1'b1, 4'd5, 1'b0);
      if (bus.ocupado === 1'b0) done = 1;
    end
    check("s1_release_idle", done, 1);

    // Scenario 2: toggling every cycle never gets accepted.
    s0 = strobes;
    for (int k = 0; k < 10; k++) step(k[0], 4'd2, 1'b0);
    for (int k = 0; k < 8; k++) step(1'b1, 4'd2, 1'b0);
    check("s2_strobes", strobes - s0, 0);
    check("s2_numero", int'(bus.numero), 5);

    // Scenario 3: long hold with a 2-cycle release glitch.
    s0 = strobes;
    for (int k = 0; k < 40; k++) step((k == 20 || k == 21), 4'd6, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 4'd6, 1'b0);
    check("s3_strobes", strobes - s0, 1);

    // Scenario 5: reset in cycle 5 of a press, then a fresh press.
    s0 = strobes;
    for (int k = 0; k < 5; k++) step(1'b0, 4'd8, 1'b0);
    step(1'b0, 4'd8, 1'b1);
    check("s5_rst_insere",   int'(bus.insere),   1);
    check("s5_rst_numero",   int'(bus.numero),   0);
    check("s5_rst_invalido", int'(bus.invalido), 0);
    check("s5_rst_ocupado",  int'(bus.ocupado),  0);
    for (int k = 0; k < 8; k++) step(1'b1, 4'd8, 1'b0);
    check("s5_no_strobe", strobes - s0, 0);
    for (int k = 0; k < 6; k++) step(1'b0, 4'd8, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b1, 4'd8, 1'b0);
    check("s5_new_strobe", strobes - s0, 1);
    check("s5_numero", int'(bus.numero), 8);

    // Scenario 6: switches change while held.
    for (int k = 0; k < 10; k++) step(1'b0, 4'd3, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 4'd7, 1'b0);
    check("s6_numero_held", int'(bus.numero), 3);
    for (int k = 0; k < 10; k++) step(1'b1, 4'd7, 1'b0);
    check("s6_numero_after", int'(bus.numero), 3);

    // Random bouncing runs against the model, with occasional resets.
    for (int k = 0; k < 400; k++) begin
      b    = 1'($urandom_range(0, 1));
      c    = 4'($urandom_range(0, 15));
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) begin
        if (j > 0 && $urandom_range(0, 3) == 0) c = 4'($urandom_range(0, 15));
        step(b, c, ($urandom_range(0, 120) == 0));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
